// File: rtl/note_pkg.sv
// Shared definitions for the note table sequencer: FSM state encoding,
//   default table base address and the bit slices of a table word.
// Latency: n/a (definitions only). Backpressure: n/a.
// Table word layout: {lane[15:12], delay[11:0]}.
package note_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    WAIT  = 3'd3,
    EMIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [15:0] NOTE_TABLE_BASE = 16'hF000;

  localparam int LANE_MSB  = 15;
  localparam int LANE_LSB  = 12;
  localparam int DELAY_MSB = 11;
  localparam int DELAY_LSB = 0;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// Latency: first tick on the TICK_DIV-th enabled cycle after clear.
// Backpressure: none; the count holds whenever enable is low.
// Ports: clk, reset (sync, active-high), clear (sync zero), enable (count),
//        tick (high on the enabled cycle where the count reaches TICK_DIV-1).
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  // One bit minimum so TICK_DIV=1 still elaborates; the count then stays 0
  // and every enabled cycle ticks.
  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/note_sequencer.sv
// Walks the note table through RAM port B, waits each entry's delay, then
//   offers its lane to the game logic.
// Latency: start -> note_valid is 3 cycles + delay*TICK_DIV; notes >= 3 cycles apart.
// Backpressure: a note stays presented (lane/idx stable) until note_ready; the
//   walk does not fetch ahead while waiting.
// Ports: clk, reset (sync, active-high), start/stop (1-cycle pulses),
//        ram_addr/ram_we/ram_q (read-only RAM port B, 1-cycle read latency),
//        note_valid/note_ready/note_lane/note_idx (note handshake), busy, done.
// Build option: define NOTE_SEQ_LOOP_EN to repeat passes until stop (done stays 0).
module note_sequencer
  import note_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = NOTE_TABLE_BASE,
  parameter int          NUM_ENTRIES = 20,
  parameter int          TICK_DIV    = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  input  logic [15:0] ram_q,
  output logic        note_valid,
  input  logic        note_ready,
  output logic [3:0]  note_lane,
  output logic [7:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_ENTRIES - 1);

  state_t      state;
  state_t      state_n;
  logic [7:0]  idx;
  logic [7:0]  idx_n;
  logic [3:0]  lane_r;
  logic [11:0] delay_r;
  logic        tick;

  // The prescaler is held at zero outside WAIT, so every WAIT starts from a
  // fresh count and nothing runs while a note is stalled in EMIT.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != WAIT),
    .enable (state == WAIT),
    .tick   (tick)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = FETCH;
          idx_n   = 8'd0;
        end
      end
      FETCH: state_n = LATCH;
      LATCH: state_n = (ram_q[DELAY_MSB:DELAY_LSB] == 12'd0) ? EMIT : WAIT;
      WAIT: begin
        // delay_r is the number of ticks still owed; the last one ends WAIT.
        if (tick && delay_r == 12'd1) state_n = EMIT;
      end
      EMIT: begin
        if (note_ready) begin
          if (idx == LAST_IDX) begin
`ifdef NOTE_SEQ_LOOP_EN
            state_n = FETCH;
            idx_n   = 8'd0;
`else
            state_n = DONE;
`endif
          end else begin
            state_n = FETCH;
            idx_n   = idx + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // stop overrides everything, including a same-cycle start or transfer.
    if (stop) begin
      state_n = IDLE;
      idx_n   = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= 8'd0;
      ram_addr <= BASE_ADDR;
      lane_r   <= 4'd0;
      delay_r  <= 12'd0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      // Address follows the next index so it is already on the RAM during FETCH.
      ram_addr <= BASE_ADDR + {8'h00, idx_n};
      if (state == LATCH) begin
        lane_r  <= ram_q[LANE_MSB:LANE_LSB];
        delay_r <= ram_q[DELAY_MSB:DELAY_LSB];
      end else if (state == WAIT && tick) begin
        delay_r <= delay_r - 12'd1;
      end
    end
  end

  assign ram_we     = 1'b0;
  assign note_valid = (state == EMIT);
  assign note_lane  = lane_r;
  assign note_idx   = idx;
  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer with a 1-cycle registered RAM model.
// Expected notes (lane, idx, cycles from start/previous transfer to valid) are
// queued when a pass is started and popped on each observed transfer.
module tb_note_sequencer;

  localparam int          TD   = 4;
  localparam int          NE   = 5;
  localparam logic [15:0] BASE = 16'hF000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_q;
  logic        note_valid;
  logic        note_ready;
  logic [3:0]  note_lane;
  logic [7:0]  note_idx;
  logic        busy;
  logic        done;

  note_sequencer #(
    .BASE_ADDR   (BASE),
    .NUM_ENTRIES (NE),
    .TICK_DIV    (TD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_q      (ram_q),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_lane  (note_lane),
    .note_idx   (note_idx),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: table at BASE..BASE+7, registered read, writes only flagged.
  logic [15:0] mem [0:7];
  logic [15:0] off;
  logic        we_seen;
  initial begin
    mem[0] = {4'd0, 12'd0};
    mem[1] = {4'd1, 12'd2};
    mem[2] = {4'd2, 12'd0};
    mem[3] = {4'd3, 12'd1};
    mem[4] = {4'd4, 12'd0};
    mem[5] = 16'hFFFF;
    mem[6] = 16'hFFFF;
    mem[7] = 16'hFFFF;
    we_seen = 1'b0;
  end
  assign off = ram_addr - BASE;
  always @(posedge clk) begin
    ram_q <= (off < 16'd8) ? mem[off[2:0]] : 16'hEEEE;
    if (ram_we === 1'b1) we_seen <= 1'b1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] lane;
    logic [7:0] idx;
    int         gap;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  task automatic push_pass();
    exp_t x;
    for (int i = 0; i < NE; i++) begin
      x.lane = mem[i][15:12];
      x.idx  = 8'(i);
      x.gap  = 3 + int'(mem[i][11:0]) * TD;
      sb.push_back(x);
    end
  endtask

  // Monitor: samples on the falling edge; inputs change 2 time units after
  // the rising edge, so values seen here are those the next edge will use.
  int         cyc = 0;
  int         ref_cyc = 0;
  int         xfer_cnt = 0;
  logic       prev_valid = 1'b0;
  logic       stalled = 1'b0;
  logic [3:0] hold_lane;
  logic [7:0] hold_idx;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      prev_valid = 1'b0;
      stalled    = 1'b0;
    end else if (stop) begin
      sb.delete();
      prev_valid = 1'b0;
      stalled    = 1'b0;
    end else begin
      if (note_valid && !prev_valid) begin
        chk("valid_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("valid_gap", 32'(cyc - ref_cyc), 32'(sb[0].gap));
      end
      if (note_valid && stalled) begin
        chk("stall_lane", 32'(note_lane), 32'(hold_lane));
        chk("stall_idx", 32'(note_idx), 32'(hold_idx));
      end
      if (note_valid && note_ready) begin
        chk("xfer_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("xfer_lane", 32'(note_lane), 32'(e.lane));
          chk("xfer_idx", 32'(note_idx), 32'(e.idx));
`ifdef NOTE_SEQ_LOOP_EN
          if (e.idx == 8'(NE - 1)) push_pass();
`endif
        end
        xfer_cnt++;
        ref_cyc = cyc;
        stalled = 1'b0;
      end else if (note_valid) begin
        stalled   = 1'b1;
        hold_lane = note_lane;
        hold_idx  = note_idx;
      end
      prev_valid = note_valid;
      if (start && !busy) ref_cyc = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input bit expect_run);
    if (expect_run) push_pass();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_valid", 32'(note_valid), 32'd0);
  endtask

  task automatic wait_xfers(input int target, input int budget);
    for (int n = 0; n < budget && xfer_cnt < target; n++) step(1);
    chk("xfer_count", 32'(xfer_cnt), 32'(target));
  endtask

  task automatic wait_idx(input logic [7:0] want);
    for (int n = 0; n < 100 && note_idx != want; n++) step(1);
    chk("reach_idx", 32'(note_idx), 32'(want));
  endtask

  task automatic end_of_pass(input int base);
`ifdef NOTE_SEQ_LOOP_EN
    chk("loop_done", 32'(done), 32'd0);
    chk("loop_addr", 32'(ram_addr), 32'(BASE));
    wait_xfers(base + NE + 1, 100);
    chk("loop_done2", 32'(done), 32'd0);
    stop_pulse();
`else
    chk("pass_done", 32'(done), 32'd1);
    chk("pass_busy", 32'(busy), 32'd0);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(ram_addr), 32'(BASE));
    chk({tag, "_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_valid"}, 32'(note_valid), 32'd0);
    chk({tag, "_lane"}, 32'(note_lane), 32'd0);
    chk({tag, "_idx"}, 32'(note_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  int base;

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    note_ready = 1'b0;
    step(3);
    check_reset_vals("rst");
    reset = 1'b0;
    step(1);

    // Full pass, ready held high.
    note_ready = 1'b1;
    base = xfer_cnt;
    pulse_start(1'b1);
    wait_xfers(base + NE, 300);
    end_of_pass(base);

    // Consumer stalls note 1 for 10 cycles.
    step(2);
    base = xfer_cnt;
    pulse_start(1'b1);
    wait_idx(8'd1);
    note_ready = 1'b0;
    for (int n = 0; n < 50 && !note_valid; n++) step(1);
    chk("stall_seen", 32'(note_valid), 32'd1);
    step(10);
    chk("stall_held", 32'(note_valid), 32'd1);
    chk("stall_addr", 32'(ram_addr), 32'(BASE + 16'd1));
    note_ready = 1'b1;
    wait_xfers(base + NE, 300);
    end_of_pass(base);

    // Stop while waiting out entry 1's delay, then replay from entry 0.
    step(2);
    pulse_start(1'b1);
    wait_idx(8'd1);
    step(5);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_novalid", 32'(note_valid), 32'd0);
    stop_pulse();
    step(20);
    chk("after_stop_valid", 32'(note_valid), 32'd0);
    base = xfer_cnt;
    pulse_start(1'b1);
    wait_xfers(base + NE, 300);
    end_of_pass(base);

    // start and stop together from IDLE: stop wins.
    stop_pulse();
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", 32'(busy), 32'd0);
    step(3);
    chk("ss_busy2", 32'(busy), 32'd0);
    chk("ss_valid", 32'(note_valid), 32'd0);

    // start pulsed mid-pass is ignored.
    base = xfer_cnt;
    pulse_start(1'b1);
    wait_idx(8'd2);
    pulse_start(1'b0);
    wait_xfers(base + NE, 300);
    end_of_pass(base);

    // Reset while a note is presented.
    step(2);
    note_ready = 1'b0;
    pulse_start(1'b1);
    for (int n = 0; n < 20 && !note_valid; n++) step(1);
    chk("emit_seen", 32'(note_valid), 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_reset_vals("midrst");
    step(3);
    chk("midrst_idle", 32'(busy), 32'd0);
    chk("ram_we_never", 32'(we_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
